// File: rtl/spi_master.sv
// spi_master: single-channel SPI master transmitter.
// Frames of DATA_WIDTH bits are shifted out LSB-first on mosi, framed by an
// active-low cs, against a free-running divided clock sclk. Everything runs in
// the clk domain. sclk is produced as data and is never used as a clock.
// Bits change on the sclk rising edge, so the slave samples on the falling edge.
module spi_master #(
   parameter int DATA_WIDTH = 12,
   parameter int CLK_DIV    = 10   // clk cycles per sclk half-period, >= 1
) (
   input  logic                  clk,
   input  logic                  rst,    // asynchronous, active low
   input  logic                  newd,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  sclk,
   output logic                  cs,
   output logic                  mosi
);

   // Divider counter width. A single bit is kept even when CLK_DIV is 1.
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // The bit index has to reach DATA_WIDTH itself, which marks the end of the frame.
   localparam int IDX_W = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_WIDTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Clock divider
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] r_div_cnt;
   logic             r_sclk;
   logic             w_div_term;
   logic             w_tick;

   assign w_div_term = (r_div_cnt == CNT_LAST);
   // The tick is high in the cycle whose closing clk edge raises sclk.
   // The FSM therefore moves on the same edge as the sclk rise.
   assign w_tick     = w_div_term & ~r_sclk;

   // Free-running half-period counter. sclk toggles at each terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_cnt <= '0;
         r_sclk    <= 1'b0;
      end else if (w_div_term) begin
         r_div_cnt <= '0;
         r_sclk    <= ~r_sclk;
      end else begin
         r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------
   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_cs;
   logic                  r_mosi;

   state_t                w_state_next;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [IDX_W-1:0]      w_idx_next;
   logic                  w_cs_next;
   logic                  w_mosi_next;
   logic [DATA_WIDTH-1:0] w_shift_adv;

   // The shift register drops one bit per tick. Its bit 0 after the shift is
   // therefore the original bit at the current index, so no variable-index
   // mux is needed.
   assign w_shift_adv = r_shift >> 1;

   // State register. Reset aborts any frame at once and does not resume it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_cs    <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_cs    <= w_cs_next;
         r_mosi  <= w_mosi_next;
      end
   end

   // Next-state logic. Nothing changes except on a tick.
   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      w_cs_next    = r_cs;
      w_mosi_next  = r_mosi;

      unique case (r_state)
         ST_IDLE: begin
            w_cs_next   = 1'b1;
            w_mosi_next = 1'b0;
            if (w_tick && newd) begin
               // Latch the word here. Later din changes cannot touch the frame.
               w_shift_next = din;
               w_cs_next    = 1'b0;
               w_mosi_next  = din[0];
               w_idx_next   = IDX_W'(1);
               w_state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            // newd and din are ignored here. A request still high at the
            // closing tick waits for the next tick in IDLE, which leaves at
            // least one full sclk period of cs high between frames.
            if (w_tick) begin
               if (r_idx < IDX_END) begin
                  w_shift_next = w_shift_adv;
                  w_mosi_next  = w_shift_adv[0];
                  w_idx_next   = r_idx + IDX_W'(1);
               end else begin
                  w_cs_next    = 1'b1;
                  w_mosi_next  = 1'b0;
                  w_idx_next   = '0;
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign sclk = r_sclk;
   assign cs   = r_cs;
   assign mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master at its default parameters (12-bit frames,
// CLK_DIV = 10). Each scenario task drives stimulus and checks its own results.
module tb_spi_master;

   localparam int DW   = 12;
   localparam int DIV  = 10;
   localparam int LOWC = DW * 2 * DIV;   // expected cs-low clk cycles: 240
   localparam int GAPC = 2 * DIV;        // expected cs-high gap when back to back: 20

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic          newd = 1'b0;
   logic [DW-1:0] din  = '0;
   logic          sclk;
   logic          cs;
   logic          mosi;

   int n_cmp = 0;
   int n_bad = 0;

   spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .newd (newd),
      .din  (din),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi)
   );

   always #5 clk = ~clk;

   // Last-resort guard so the run always ends.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
      $fatal(1);
   end

   // Waits at negedges for cs to fall, counting high cycles. It then records
   // mosi at every sclk fall while cs stays low, and counts the low cycles.
   // It returns at the first negedge where cs is high again.
   task automatic capture_frame(input bit release_newd,
                                output logic [DW-1:0] word, output int nbits,
                                output int low, output int hi,
                                output logic first_mosi, output logic first_sclk,
                                output bit timed_out);
      logic prev;
      word = '0; nbits = 0; low = 0; hi = 0; timed_out = 1'b0;
      first_mosi = 1'bx; first_sclk = 1'bx;
      while (cs !== 1'b0 && hi < 2000) begin
         hi++;
         @(negedge clk);
      end
      if (cs !== 1'b0) begin
         timed_out = 1'b1;
         return;
      end
      if (release_newd) newd = 1'b0;
      first_mosi = mosi;
      first_sclk = sclk;
      prev = sclk;
      while (cs === 1'b0 && low < 1000) begin
         low++;
         if (prev === 1'b1 && sclk === 1'b0) begin
            if (nbits < DW) word[nbits] = mosi;
            nbits++;
         end
         prev = sclk;
         @(negedge clk);
      end
      if (cs !== 1'b1) timed_out = 1'b1;
   endtask

   task automatic test_reset;
      int n;
      logic last;
      rst = 1'b0; newd = 1'b0; din = '0;
      repeat (5) @(negedge clk);
      n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b required=0", sclk); end
      n_cmp++; if (cs   !== 1'b1) begin n_bad++; $display("FAIL reset_cs got=%b required=1", cs); end
      n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b required=0", mosi); end
      rst = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sclk !== 1'b1 && n < 50);
      n_cmp++; if (n !== DIV) begin n_bad++; $display("FAIL first_sclk_rise got=%0d required=%0d", n, DIV); end
      for (int t = 0; t < 3; t++) begin
         last = sclk;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (sclk === last && n < 50);
         n_cmp++; if (n !== DIV) begin n_bad++; $display("FAIL sclk_half_period_%0d got=%0d required=%0d", t, n, DIV); end
      end
      n_cmp++; if (cs   !== 1'b1) begin n_bad++; $display("FAIL idle_cs got=%b required=1", cs); end
      n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL idle_mosi got=%b required=0", mosi); end
      $display("reset: sclk half-period checked, idle outputs checked");
   endtask

   task automatic test_single_frame;
      logic [DW-1:0] w; int nb, lo, hi; logic fm, fs; bit to;
      din = 12'hA5C; newd = 1'b1;
      capture_frame(1'b1, w, nb, lo, hi, fm, fs, to);
      n_cmp++; if (to)          begin n_bad++; $display("FAIL single_timeout got=1 required=0"); end
      n_cmp++; if (w !== 12'hA5C) begin n_bad++; $display("FAIL single_word got=%h required=a5c", w); end
      n_cmp++; if (nb !== DW)   begin n_bad++; $display("FAIL single_nbits got=%0d required=%0d", nb, DW); end
      n_cmp++; if (lo !== LOWC) begin n_bad++; $display("FAIL single_cs_low got=%0d required=%0d", lo, LOWC); end
      n_cmp++; if (fm !== 1'b0) begin n_bad++; $display("FAIL single_first_mosi got=%b required=0", fm); end
      n_cmp++; if (fs !== 1'b1) begin n_bad++; $display("FAIL single_sclk_at_cs_fall got=%b required=1", fs); end
      $display("single: sent=a5c got=%h bits=%0d cs_low=%0d", w, nb, lo);
   endtask

   task automatic test_random_frames;
      logic [DW-1:0] w, d; int nb, lo, hi; logic fm, fs; bit to;
      for (int f = 0; f < 20; f++) begin
         d = DW'($urandom_range(0, (1 << DW) - 1));
         din = d; newd = 1'b1;
         capture_frame(1'b1, w, nb, lo, hi, fm, fs, to);
         n_cmp++; if (to || w !== d) begin n_bad++; $display("FAIL rand_word_%0d got=%h required=%h timeout=%0d", f, w, d, to); end
         n_cmp++; if (nb !== DW || lo !== LOWC) begin n_bad++; $display("FAIL rand_shape_%0d got=bits %0d low %0d required=bits %0d low %0d", f, nb, lo, DW, LOWC); end
         n_cmp++; if (fm !== d[0]) begin n_bad++; $display("FAIL rand_first_mosi_%0d got=%b required=%b", f, fm, d[0]); end
         if (f > 0) begin
            n_cmp++; if (hi < GAPC) begin n_bad++; $display("FAIL rand_gap_%0d got=%0d required>=%0d", f, hi, GAPC); end
         end
         $display("random %0d: sent=%h got=%h bits=%0d cs_low=%0d gap=%0d", f, d, w, nb, lo, hi);
      end
   endtask

   task automatic test_din_change;
      logic [DW-1:0] w; int nb, lo, hi, n, lows; logic fm, fs; bit to;
      din = 12'h000; newd = 1'b1;
      fork
         capture_frame(1'b1, w, nb, lo, hi, fm, fs, to);
         begin
            n = 0;
            while (cs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
            repeat (100) @(negedge clk);
            din = 12'hFFF; newd = 1'b1;
            repeat (40) @(negedge clk);
            newd = 1'b0;
         end
      join
      n_cmp++; if (to || w !== 12'h000) begin n_bad++; $display("FAIL din_change_word got=%h required=000 timeout=%0d", w, to); end
      n_cmp++; if (lo !== LOWC) begin n_bad++; $display("FAIL din_change_cs_low got=%0d required=%0d", lo, LOWC); end
      $display("din_change: sent=000 got=%h bits=%0d cs_low=%0d", w, nb, lo);
      lows = 0;
      repeat (100) begin
         if (cs === 1'b0) lows++;
         @(negedge clk);
      end
      n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL din_change_no_extra_frame got=%0d low cycles required=0", lows); end
      newd = 1'b1;
      capture_frame(1'b1, w, nb, lo, hi, fm, fs, to);
      n_cmp++; if (to || w !== 12'hFFF) begin n_bad++; $display("FAIL din_change_next_word got=%h required=fff timeout=%0d", w, to); end
      $display("din_change: sent=fff got=%h bits=%0d cs_low=%0d", w, nb, lo);
   endtask

   task automatic test_reset_midframe;
      logic [DW-1:0] w; int nb, lo, hi, n; logic fm, fs; bit to;
      din = 12'h3C5; newd = 1'b1;
      n = 0;
      while (cs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      newd = 1'b0;
      // Five bit periods plus part of one more: bit 5 is on the wire with sclk high.
      repeat (104) @(negedge clk);
      n_cmp++; if (cs !== 1'b0) begin n_bad++; $display("FAIL midframe_cs_before_reset got=%b required=0", cs); end
      rst = 1'b0;
      #1;
      n_cmp++; if (cs   !== 1'b1) begin n_bad++; $display("FAIL midframe_reset_cs got=%b required=1", cs); end
      n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL midframe_reset_mosi got=%b required=0", mosi); end
      n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL midframe_reset_sclk got=%b required=0", sclk); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      din = 12'h5A3; newd = 1'b1;
      capture_frame(1'b1, w, nb, lo, hi, fm, fs, to);
      n_cmp++; if (to || w !== 12'h5A3) begin n_bad++; $display("FAIL after_reset_word got=%h required=5a3 timeout=%0d", w, to); end
      n_cmp++; if (nb !== DW || lo !== LOWC) begin n_bad++; $display("FAIL after_reset_shape got=bits %0d low %0d required=bits %0d low %0d", nb, lo, DW, LOWC); end
      $display("reset_midframe: aborted 3c5, then sent=5a3 got=%h bits=%0d cs_low=%0d", w, nb, lo);
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] w; int nb, lo, hi; logic fm, fs; bit to;
      din = 12'h001; newd = 1'b1;
      for (int f = 0; f < 3; f++) begin
         capture_frame(1'b0, w, nb, lo, hi, fm, fs, to);
         n_cmp++; if (to || w !== 12'h001) begin n_bad++; $display("FAIL b2b_word_%0d got=%h required=001 timeout=%0d", f, w, to); end
         n_cmp++; if (lo !== LOWC) begin n_bad++; $display("FAIL b2b_cs_low_%0d got=%0d required=%0d", f, lo, LOWC); end
         if (f > 0) begin
            n_cmp++; if (hi !== GAPC) begin n_bad++; $display("FAIL b2b_gap_%0d got=%0d required=%0d", f, hi, GAPC); end
         end
         $display("back_to_back %0d: sent=001 got=%h cs_low=%0d gap=%0d", f, w, lo, hi);
      end
      newd = 1'b0;
      repeat (30) @(negedge clk);
      n_cmp++; if (cs !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_after got=%b required=1", cs); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_random_frames();
      test_din_change();
      test_reset_midframe();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
